mux8_rr_arbiter: RTL and testbench
==================================

# mux8_rr_arbiter

Round-robin arbiter and select controller for the 8:1 single-bit mux (`mux8to1`). It shares the mux between eight requesters: it grants one requester at a time, drives the mux `sel` from the granted index, and bounds how long any grant is held. It also provides a registered copy of the selected data bit. It sits directly upstream of the mux select and is the only driver of `sel` in the datapath.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is waiting. Legal range is 1..15.
- `clk`, input, 1: rising-edge clock; the single clock of the block.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, 8: request per requester; `req[k]` is requester k.
- `d`, input, 8: data bit per requester; the same vector fed to the mux.
- `gnt`, output, 8: one-hot grant, registered; all zero when idle.
- `sel`, output, 3: index of the granted requester, registered; drives the mux select.
- `gnt_valid`, output, 1: high while a grant is active; equals `|gnt`.
- `y_q`, output, 1: registered `d[sel]` when a grant is active, else 0.

## Operation
- State `ptr[2:0]` is the round-robin start index. It resets to 0.
- State `hold_cnt[3:0]` counts grant cycles.
- FSM states:
  - **IDLE** (reset state): `gnt=0`, `gnt_valid=0`.
  - **GRANT**: exactly one `gnt` bit is set, `gnt_valid=1`, `sel` is the index of that bit.
- **Priority search:** the winner is the first k with `req[k]=1`, scanning `ptr, ptr+1, …, ptr+7` with the index taken mod 8 (3-bit wrap, 7 is followed by 0).
- **IDLE → GRANT:** when `|req`. The winner is granted, `hold_cnt` is set to 1, and `ptr` is unchanged.
- **GRANT, release condition:** release when `req[sel]=0` (normal release), or when `hold_cnt>=MAX_HOLD` and some `req[j]=1` with `j!=sel` (preempt).
- **GRANT, on release:**
  - `ptr` becomes `sel+1` mod 8.
  - Rerun the priority search using the new `ptr` and the current `req`.
  - If there is a winner: grant it back-to-back with no idle cycle, and set `hold_cnt` to 1. A preempted requester whose `req` is still high competes normally and lands at the back of the order.
  - If there is no winner: go to IDLE.
- **GRANT, no release:** the grant is held and `hold_cnt` increments, saturating at 15. If `hold_cnt>=MAX_HOLD` but no other requester is waiting, the grant continues indefinitely.
- **`y_q`:** updates every cycle to `d[sel]` of the registered `sel` when `gnt_valid`, else 0.
- **Reset values:** `gnt=0`, `sel=0`, `gnt_valid=0`, `y_q=0`, `ptr=0`, `hold_cnt=0`, state IDLE.
- **Reset mid-operation:** asserting `rst_n` low forces all of the reset values immediately and asynchronously, without waiting for a clock edge. After release, arbitration restarts from `ptr=0`.

## Timing
- **Request to grant:** `req` is sampled at edge t, and `gnt`/`sel`/`gnt_valid` are valid after edge t. Latency is 1 cycle.
- **Release:** `req[sel]` low before edge t means `gnt` moves or clears at edge t. The released requester holds at most one extra cycle beyond its last `req` cycle.
- **Preempt:** a grant issued at edge t0 with competing requests is withdrawn at edge t0+`MAX_HOLD`. The requester therefore owns exactly `MAX_HOLD` cycles.
- **`y_q`:** lags `sel` by one cycle, since it is registered from the registered `sel`.
- **Simultaneous events:** a new `req` arriving in the release cycle participates in that same re-search.
- **`rst_n` deassertion:** is synchronous to `clk` at system level. The first grant is possible at the first edge after deassertion.
- **Output stability:** no combinational path from `req` to `gnt` or `sel`; all outputs are registered.

## Test plan
- **Reset:** hold `rst_n=0` with `req=8'hFF` → `gnt=0`, `sel=0`, `gnt_valid=0`, `y_q=0`. Pull `rst_n` low mid-grant → all outputs 0 immediately, before the next edge.
- **Single requester:** `req=8'b0000_1000` for 6 cycles, then 0 → `gnt=8'h08` and `sel=3`, 1 cycle after `req`. The grant is held for 6 cycles despite `MAX_HOLD=4`, since no one else is waiting. It clears the edge after `req` drops.
- **Rotation with preemption:** `req=8'hFF` held, `MAX_HOLD=4`, `d=8'b1010_1010` → `sel` steps 0,1,2,…,7,0, each held exactly 4 cycles. `y_q` shows 0,1,0,1,… lagging `sel` by 1 cycle.
- **Wrap-around:** grant to 7 with `req[7]` and `req[1]` both high → after release or preempt, the next grant is 1 and `ptr=0`.
- **Back-to-back handoff:** `req[2]` and `req[5]` high; drop `req[2]` after 2 grant cycles → `gnt` moves from `8'h04` to `8'h20` at the same edge, with no idle cycle and `gnt_valid` continuously 1.
- **Fairness after release:** after grant 5 releases, `ptr=6`. Then `req=8'b0110_0001` → `sel=6` first, then 0, then 5.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter and select controller for the 8:1 mux
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid,
    output logic       y_q
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state, w_state_n;
    logic [2:0] r_ptr, w_ptr_n;
    logic [3:0] r_hold_cnt, w_hold_n;
    logic [7:0] r_gnt, w_gnt_n;
    logic [2:0] r_sel, w_sel_n;
    logic       r_y_q, w_y_n;

    logic [3:0] w_idle_srch;
    logic [3:0] w_rel_srch;
    logic [2:0] w_rel_ptr;
    logic       w_others;
    logic       w_release;

    // Returns {found, index} of the first set bit scanning start, start+1, ... with 3-bit wrap.
    function automatic logic [3:0] f_search(input logic [2:0] start, input logic [7:0] vec);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            idx = start + 3'(i);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign w_rel_ptr   = r_sel + 3'd1;
    assign w_idle_srch = f_search(r_ptr, req);
    assign w_rel_srch  = f_search(w_rel_ptr, req);
    // r_gnt is the one-hot of r_sel while granting, so masking with it isolates competitors.
    assign w_others    = |(req & ~r_gnt);
    assign w_release   = !req[r_sel] || ((r_hold_cnt >= HOLD_LIM) && w_others);

    // Next-state, grant selection and hold counting.
    always_comb begin
        w_state_n = r_state;
        w_ptr_n   = r_ptr;
        w_hold_n  = r_hold_cnt;
        w_gnt_n   = r_gnt;
        w_sel_n   = r_sel;
        w_y_n     = (|r_gnt) ? d[r_sel] : 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_idle_srch[3]) begin
                    w_state_n = S_GRANT;
                    w_gnt_n   = 8'd1 << w_idle_srch[2:0];
                    w_sel_n   = w_idle_srch[2:0];
                    w_hold_n  = 4'd1;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_n = w_rel_ptr;
                    if (w_rel_srch[3]) begin
                        w_gnt_n  = 8'd1 << w_rel_srch[2:0];
                        w_sel_n  = w_rel_srch[2:0];
                        w_hold_n = 4'd1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_gnt_n   = 8'd0;
                        w_hold_n  = 4'd0;
                    end
                end else if (r_hold_cnt != 4'd15) begin
                    w_hold_n = r_hold_cnt + 4'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_gnt_n   = 8'd0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 3'd0;
            r_hold_cnt <= 4'd0;
            r_gnt      <= 8'd0;
            r_sel      <= 3'd0;
            r_y_q      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_ptr      <= w_ptr_n;
            r_hold_cnt <= w_hold_n;
            r_gnt      <= w_gnt_n;
            r_sel      <= w_sel_n;
            r_y_q      <= w_y_n;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign gnt_valid = |r_gnt;
    assign y_q       = r_y_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - scoreboard bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       gnt_valid;
    logic       y_q;

    int n_checks;
    int n_errors;

    typedef struct {
        string      tag;
        logic [7:0] gnt;
        logic [2:0] sel;
        bit         chk_sel;
        logic       y;
    } exp_t;

    exp_t exp_q[$];

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d         (d),
        .gnt       (gnt),
        .sel       (sel),
        .gnt_valid (gnt_valid),
        .y_q       (y_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void push_exp(input string tag, input logic [7:0] eg, input logic [2:0] es,
                                     input bit cs, input logic ey);
        exp_t e;
        e.tag = tag; e.gnt = eg; e.sel = es; e.chk_sel = cs; e.y = ey;
        exp_q.push_back(e);
    endfunction

    // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
    task automatic cyc(input string tag, input logic [7:0] r, input logic [7:0] dd,
                       input logic [7:0] eg, input logic [2:0] es, input bit cs, input logic ey);
        @(negedge clk);
        req = r;
        d   = dd;
        push_exp(tag, eg, es, cs, ey);
    endtask

    // Monitor: compares outputs shortly after each rising edge against the oldest expectation.
    initial begin
        exp_t e;
        logic exp_gv;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                exp_gv = (e.gnt != 8'd0);
                n_checks++;
                if (gnt !== e.gnt || gnt_valid !== exp_gv || y_q !== e.y ||
                    (e.chk_sel && sel !== e.sel)) begin
                    n_errors++;
                    $display("FAIL %s: got gnt=%h sel=%0d gnt_valid=%b y_q=%b, expected gnt=%h sel=%0d gnt_valid=%b y_q=%b",
                             e.tag, gnt, sel, gnt_valid, y_q, e.gnt, e.sel, exp_gv, e.y);
                end
            end
        end
    end

    initial begin
        int c;
        int s;
        int ps;
        logic [7:0] rot_d;
        rst_n = 1'b0;
        req   = 8'hFF;
        d     = 8'h00;
        n_checks = 0;
        n_errors = 0;

        // Reset held with all requests high.
        cyc("reset_hold0", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        cyc("reset_hold1", 8'hFF, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 8'h00;
        push_exp("reset_release", 8'h00, 3'd0, 1'b1, 1'b0);

        // Single requester 3 held 6 cycles; no competitor so MAX_HOLD does not apply.
        cyc("single_first", 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc("single_hold", 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1);
        cyc("single_clear", 8'h00, 8'h08, 8'h00, 3'd0, 1'b0, 1'b1);
        cyc("single_idle", 8'h00, 8'h08, 8'h00, 3'd0, 1'b0, 1'b0);

        // Fairness: grant 5 then release, ptr=6; req=0110_0001 yields 6, 0, 5, 6.
        cyc("fair_g5a", 8'h20, 8'h41, 8'h20, 3'd5, 1'b1, 1'b0);
        cyc("fair_g5b", 8'h20, 8'h41, 8'h20, 3'd5, 1'b1, 1'b0);
        cyc("fair_rel5", 8'h00, 8'h41, 8'h00, 3'd0, 1'b0, 1'b0);
        cyc("fair_g6_first", 8'h61, 8'h41, 8'h40, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("fair_g6_hold", 8'h61, 8'h41, 8'h40, 3'd6, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc("fair_g0", 8'h61, 8'h41, 8'h01, 3'd0, 1'b1, 1'b1);
        cyc("fair_g5_first", 8'h61, 8'h41, 8'h20, 3'd5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("fair_g5_hold", 8'h61, 8'h41, 8'h20, 3'd5, 1'b1, 1'b0);
        cyc("fair_g6_again", 8'h61, 8'h41, 8'h40, 3'd6, 1'b1, 1'b0);
        cyc("fair_clear", 8'h00, 8'h41, 8'h00, 3'd0, 1'b0, 1'b1);
        cyc("fair_idle", 8'h00, 8'h41, 8'h00, 3'd0, 1'b0, 1'b0);

        // Wrap-around: ptr=7, grant 7, preempt wraps to 1; then 7 wins over 0 from ptr=2.
        cyc("wrap_g7_first", 8'h82, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("wrap_g7_hold", 8'h82, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1);
        cyc("wrap_g1", 8'h82, 8'h80, 8'h02, 3'd1, 1'b1, 1'b1);
        cyc("wrap_rel1_g7", 8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
        cyc("wrap_clear", 8'h00, 8'h80, 8'h00, 3'd0, 1'b0, 1'b1);
        cyc("wrap_idle", 8'h00, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0);

        // Back-to-back handoff 2 -> 5 with no idle cycle (ptr=0).
        cyc("b2b_g2a", 8'h24, 8'h24, 8'h04, 3'd2, 1'b1, 1'b0);
        cyc("b2b_g2b", 8'h24, 8'h24, 8'h04, 3'd2, 1'b1, 1'b1);
        cyc("b2b_g5a", 8'h20, 8'h24, 8'h20, 3'd5, 1'b1, 1'b1);
        cyc("b2b_g5b", 8'h20, 8'h24, 8'h20, 3'd5, 1'b1, 1'b1);
        cyc("b2b_clear", 8'h00, 8'h24, 8'h00, 3'd0, 1'b0, 1'b1);
        cyc("b2b_idle", 8'h00, 8'h24, 8'h00, 3'd0, 1'b0, 1'b0);

        // Mid-grant asynchronous reset (ptr=6 so requester 6 wins first).
        cyc("mid_g6a", 8'hFF, 8'hAA, 8'h40, 3'd6, 1'b1, 1'b0);
        cyc("mid_g6b", 8'hFF, 8'hAA, 8'h40, 3'd6, 1'b1, 1'b0);
        cyc("mid_g6c", 8'hFF, 8'hAA, 8'h40, 3'd6, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || gnt_valid !== 1'b0 || y_q !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got gnt=%h sel=%0d gnt_valid=%b y_q=%b, expected all zero",
                     gnt, sel, gnt_valid, y_q);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Rotation from ptr=0 with all requests: each index owns exactly 4 cycles, 0..7 then 0.
        rot_d = 8'hAA;
        for (c = 0; c < 36; c++) begin
            s  = (c / 4) % 8;
            ps = ((c - 1) / 4) % 8;
            if (c == 0) begin
                push_exp("rot", 8'd1 << s, 3'(s), 1'b1, 1'b0);
                req = 8'hFF;
                d   = rot_d;
            end else begin
                cyc("rot", 8'hFF, rot_d, 8'd1 << s, 3'(s), 1'b1, rot_d[ps]);
            end
        end
        cyc("rot_clear", 8'h00, rot_d, 8'h00, 3'd0, 1'b0, rot_d[0]);
        cyc("rot_idle", 8'h00, rot_d, 8'h00, 3'd0, 1'b0, 1'b0);

        // Let the monitor drain, with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
